// File: rtl/branch_operand_fwd_if.sv
// Bundle between the pipeline and the ID-stage branch operand forwarding unit.
// master drives pipeline-side inputs; slave is the forwarding unit.
`timescale 1ns/1ps
interface branch_operand_fwd_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned NUM_SRC = 2
);
  logic                        flush;
  logic                        id_branch;
  logic [NUM_SRC*REG_AW-1:0]   id_src_addr;
  logic [NUM_SRC*DATA_W-1:0]   rf_rdata;
  logic                        ex_wr_en;
  logic [REG_AW-1:0]           ex_wr_addr;
  logic                        ex_is_load;
  logic [DATA_W-1:0]           ex_alu_result;
  logic                        mem_wr_en;
  logic [REG_AW-1:0]           mem_wr_addr;
  logic                        mem_is_load;
  logic [DATA_W-1:0]           mem_result;
  logic                        wb_wr_en;
  logic [REG_AW-1:0]           wb_wr_addr;
  logic [DATA_W-1:0]           wb_wdata;
  logic [NUM_SRC*DATA_W-1:0]   op_data;
  logic [NUM_SRC*2-1:0]        fwd_sel;
  logic                        op_valid;
  logic                        stall_id;
  logic [31:0]                 stall_cycles;
  logic [31:0]                 fwd_events;

  modport master (
    output flush, id_branch, id_src_addr, rf_rdata,
    output ex_wr_en, ex_wr_addr, ex_is_load, ex_alu_result,
    output mem_wr_en, mem_wr_addr, mem_is_load, mem_result,
    output wb_wr_en, wb_wr_addr, wb_wdata,
    input  op_data, fwd_sel, op_valid, stall_id, stall_cycles, fwd_events
  );

  modport slave (
    input  flush, id_branch, id_src_addr, rf_rdata,
    input  ex_wr_en, ex_wr_addr, ex_is_load, ex_alu_result,
    input  mem_wr_en, mem_wr_addr, mem_is_load, mem_result,
    input  wb_wr_en, wb_wr_addr, wb_wdata,
    output op_data, fwd_sel, op_valid, stall_id, stall_cycles, fwd_events
  );
endinterface

// File: rtl/branch_operand_fwd.sv
// Operand forwarding and load-use stall unit for the ID-stage branch comparator.
// Optional performance counters enabled by defining BRANCH_FWD_PERF_CNT_EN.
`timescale 1ns/1ps
module branch_operand_fwd #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned NUM_SRC = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  branch_operand_fwd_if.slave   fwd_bus
);

  typedef enum logic [0:0] {StIdle, StStall} state_e;

  state_e                     r_state, w_state_nxt;
  logic [1:0]                 r_cnt, w_cnt_nxt;
  logic [NUM_SRC*2-1:0]       w_fwd_sel;
  logic [NUM_SRC*DATA_W-1:0]  w_op_data;
  logic [NUM_SRC*2-1:0]       w_need_vec;
  logic [1:0]                 w_need;
  logic                       w_stall;
  logic                       w_stall_id;
  logic                       w_op_valid;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_ch
    logic [REG_AW-1:0] w_src;
    logic              w_ex_hit, w_mem_hit, w_wb_hit;
    logic [1:0]        w_sel;
    logic [DATA_W-1:0] w_data;

    assign w_src     = fwd_bus.id_src_addr[k*REG_AW +: REG_AW];
    // r0 is hard-wired zero, so it never matches a producer.
    assign w_ex_hit  = fwd_bus.ex_wr_en  && (fwd_bus.ex_wr_addr  == w_src) && (w_src != '0);
    assign w_mem_hit = fwd_bus.mem_wr_en && (fwd_bus.mem_wr_addr == w_src) && (w_src != '0);
    assign w_wb_hit  = fwd_bus.wb_wr_en  && (fwd_bus.wb_wr_addr  == w_src) && (w_src != '0);

    always_comb begin
      if (w_ex_hit)       w_sel = 2'b10;
      else if (w_mem_hit) w_sel = 2'b11;
      else if (w_wb_hit)  w_sel = 2'b01;
      else                w_sel = 2'b00;
    end

    always_comb begin
      unique case (w_sel)
        2'b10: w_data = fwd_bus.ex_alu_result;
        2'b11: w_data = fwd_bus.mem_result;
        2'b01: w_data = fwd_bus.wb_wdata;
        2'b00: w_data = fwd_bus.rf_rdata[k*DATA_W +: DATA_W];
      endcase
    end

    assign w_need_vec[k*2 +: 2] = (w_ex_hit && fwd_bus.ex_is_load)   ? 2'd2 :
                                  (w_mem_hit && fwd_bus.mem_is_load) ? 2'd1 : 2'd0;
    assign w_fwd_sel[k*2 +: 2]         = w_sel;
    assign w_op_data[k*DATA_W +: DATA_W] = w_data;
  end

  always_comb begin
    w_need = 2'd0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (w_need_vec[k*2 +: 2] > w_need) w_need = w_need_vec[k*2 +: 2];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stall     = 1'b0;
    if (fwd_bus.flush) begin
      w_state_nxt = StIdle;
      w_cnt_nxt   = 2'd0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (fwd_bus.id_branch && (w_need != 2'd0)) begin
            w_stall     = 1'b1;
            w_cnt_nxt   = w_need - 2'd1;
            w_state_nxt = (w_need == 2'd2) ? StStall : StIdle;
          end
        end
        StStall: begin
          // Producer inputs are not consulted; the load's timing is already known.
          w_stall   = 1'b1;
          w_cnt_nxt = r_cnt - 2'd1;
          if (r_cnt <= 2'd1) begin
            w_state_nxt = StIdle;
            w_cnt_nxt   = 2'd0;
          end
        end
        default: begin
          w_state_nxt = StIdle;
          w_cnt_nxt   = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign w_stall_id = rst_n && w_stall;
  assign w_op_valid = rst_n && fwd_bus.id_branch && !w_stall_id && !fwd_bus.flush;

  assign fwd_bus.fwd_sel  = w_fwd_sel;
  assign fwd_bus.op_data  = w_op_data;
  assign fwd_bus.stall_id = w_stall_id;
  assign fwd_bus.op_valid = w_op_valid;

`ifdef BRANCH_FWD_PERF_CNT_EN
  logic [31:0] r_stall_cycles, r_fwd_events;
  logic        w_any_fwd;

  assign w_any_fwd = |w_fwd_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
      r_fwd_events   <= '0;
    end else begin
      if (w_stall_id && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_op_valid && w_any_fwd && (r_fwd_events != '1)) r_fwd_events <= r_fwd_events + 32'd1;
    end
  end

  assign fwd_bus.stall_cycles = r_stall_cycles;
  assign fwd_bus.fwd_events   = r_fwd_events;
`else
  assign fwd_bus.stall_cycles = '0;
  assign fwd_bus.fwd_events   = '0;
`endif

endmodule

// File: tb/tb_branch_operand_fwd.sv
// Randomized self-checking bench for branch_operand_fwd against a remaining-stall-count model.
`timescale 1ns/1ps
module tb_branch_operand_fwd;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NS = 2;

  logic clk;
  logic rst_n;

  branch_operand_fwd_if #(.DATA_W(DW), .REG_AW(AW), .NUM_SRC(NS)) bus ();

  branch_operand_fwd #(.DATA_W(DW), .REG_AW(AW), .NUM_SRC(NS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .fwd_bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model state: stall cycles still owed after the current cycle.
  int          m_rem;
  int          m_rem_nxt;
  logic [31:0] m_stall_cnt;
  logic [31:0] m_fwd_cnt;
  logic        e_stall;
  logic        e_valid;
  logic        e_any_fwd;
  logic [1:0]  e_sel  [NS];
  logic [DW-1:0] e_data [NS];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_eval();
    int need;
    int ch_need;
    logic [AW-1:0] s;
    logic ex_hit, mem_hit, wb_hit;
    need = 0;
    e_any_fwd = 1'b0;
    for (int k = 0; k < NS; k++) begin
      s       = bus.id_src_addr[k*AW +: AW];
      ex_hit  = (s != 0) && bus.ex_wr_en  && (bus.ex_wr_addr  == s);
      mem_hit = (s != 0) && bus.mem_wr_en && (bus.mem_wr_addr == s);
      wb_hit  = (s != 0) && bus.wb_wr_en  && (bus.wb_wr_addr  == s);
      if (ex_hit) begin
        e_sel[k] = 2'b10; e_data[k] = bus.ex_alu_result;
      end else if (mem_hit) begin
        e_sel[k] = 2'b11; e_data[k] = bus.mem_result;
      end else if (wb_hit) begin
        e_sel[k] = 2'b01; e_data[k] = bus.wb_wdata;
      end else begin
        e_sel[k] = 2'b00; e_data[k] = bus.rf_rdata[k*DW +: DW];
      end
      if (e_sel[k] != 2'b00) e_any_fwd = 1'b1;
      if (ex_hit && bus.ex_is_load)        ch_need = 2;
      else if (mem_hit && bus.mem_is_load) ch_need = 1;
      else                                 ch_need = 0;
      if (ch_need > need) need = ch_need;
    end
    if (!rst_n) begin
      m_rem = 0; m_stall_cnt = '0; m_fwd_cnt = '0;
      e_stall = 1'b0; m_rem_nxt = 0;
    end else if (bus.flush) begin
      e_stall = 1'b0; m_rem_nxt = 0;
    end else if (m_rem > 0) begin
      e_stall = 1'b1; m_rem_nxt = m_rem - 1;
    end else if (bus.id_branch && need > 0) begin
      e_stall = 1'b1; m_rem_nxt = need - 1;
    end else begin
      e_stall = 1'b0; m_rem_nxt = 0;
    end
    e_valid = rst_n && bus.id_branch && !e_stall && !bus.flush;
  endfunction

  function automatic void model_commit();
    if (!rst_n) begin
      m_rem = 0; m_stall_cnt = '0; m_fwd_cnt = '0;
    end else begin
      m_rem = m_rem_nxt;
      if (e_stall && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt = m_stall_cnt + 1;
      if (e_valid && e_any_fwd && m_fwd_cnt != 32'hFFFF_FFFF) m_fwd_cnt = m_fwd_cnt + 1;
    end
  endfunction

  // Called at the negedge; checks against the model, then advances one clock.
  task automatic cyc();
    model_eval();
    chk("stall_id", bus.stall_id, e_stall);
    chk("op_valid", bus.op_valid, e_valid);
    for (int k = 0; k < NS; k++) begin
      chk("fwd_sel", bus.fwd_sel[k*2 +: 2], e_sel[k]);
      chk("op_data", bus.op_data[k*DW +: DW], e_data[k]);
    end
`ifdef BRANCH_FWD_PERF_CNT_EN
    chk("stall_cycles", bus.stall_cycles, m_stall_cnt);
    chk("fwd_events", bus.fwd_events, m_fwd_cnt);
`else
    chk("stall_cycles", bus.stall_cycles, 64'd0);
    chk("fwd_events", bus.fwd_events, 64'd0);
`endif
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic idle_inputs();
    bus.flush = 1'b0;       bus.id_branch = 1'b0;
    bus.id_src_addr = '0;   bus.rf_rdata = '0;
    bus.ex_wr_en = 1'b0;    bus.ex_wr_addr = '0;  bus.ex_is_load = 1'b0;  bus.ex_alu_result = '0;
    bus.mem_wr_en = 1'b0;   bus.mem_wr_addr = '0; bus.mem_is_load = 1'b0; bus.mem_result = '0;
    bus.wb_wr_en = 1'b0;    bus.wb_wr_addr = '0;  bus.wb_wdata = '0;
  endtask

  initial begin
    logic [31:0] exp_sc;
    clk = 1'b0; rst_n = 1'b0;
    m_rem = 0; m_rem_nxt = 0; m_stall_cnt = '0; m_fwd_cnt = '0;
    idle_inputs();
    bus.id_branch = 1'b1;
    bus.ex_wr_en = 1'b1; bus.ex_wr_addr = 5'd1; bus.ex_is_load = 1'b1;
    bus.id_src_addr = {5'd0, 5'd1};

    // Reset with a load hazard present: stall and op_valid must stay low.
    @(negedge clk);
    chk("rst_stall", bus.stall_id, 1'b0);
    chk("rst_valid", bus.op_valid, 1'b0);
    cyc();
    rst_n = 1'b1;

    // EX forwarding, non-load.
    idle_inputs();
    bus.id_branch = 1'b1; bus.id_src_addr = {5'd0, 5'd5}; bus.rf_rdata = {32'h0, 32'h5555};
    bus.ex_wr_en = 1'b1; bus.ex_wr_addr = 5'd5; bus.ex_alu_result = 32'h1234;
    @(negedge clk);
    chk("ex_sel", bus.fwd_sel[1:0], 2'b10);
    chk("ex_data", bus.op_data[31:0], 32'h1234);
    chk("ex_stall", bus.stall_id, 1'b0);
    chk("ex_valid", bus.op_valid, 1'b1);
    cyc();

    // EX load: two stall cycles, then WB forwarding.
    idle_inputs();
    bus.id_branch = 1'b1; bus.id_src_addr = {5'd0, 5'd7};
    bus.ex_wr_en = 1'b1; bus.ex_wr_addr = 5'd7; bus.ex_is_load = 1'b1;
    @(negedge clk); chk("ld_stall1", bus.stall_id, 1'b1); cyc();
    bus.ex_wr_en = 1'b0; bus.ex_is_load = 1'b0;
    bus.mem_wr_en = 1'b1; bus.mem_wr_addr = 5'd7; bus.mem_is_load = 1'b1;
    @(negedge clk); chk("ld_stall2", bus.stall_id, 1'b1); cyc();
    bus.mem_wr_en = 1'b0; bus.mem_is_load = 1'b0;
    bus.wb_wr_en = 1'b1; bus.wb_wr_addr = 5'd7; bus.wb_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("ld_stall3", bus.stall_id, 1'b0);
    chk("ld_wb_sel", bus.fwd_sel[1:0], 2'b01);
    chk("ld_wb_data", bus.op_data[31:0], 32'hDEAD_BEEF);
    chk("ld_valid", bus.op_valid, 1'b1);
    cyc();

    // MEM load on ch0, EX load on ch1: max requirement is 2.
    idle_inputs();
    bus.id_branch = 1'b1; bus.id_src_addr = {5'd4, 5'd3};
    bus.mem_wr_en = 1'b1; bus.mem_wr_addr = 5'd3; bus.mem_is_load = 1'b1;
    bus.ex_wr_en = 1'b1; bus.ex_wr_addr = 5'd4; bus.ex_is_load = 1'b1;
    @(negedge clk); chk("mx_stall1", bus.stall_id, 1'b1); cyc();
    bus.ex_wr_en = 1'b0; bus.ex_is_load = 1'b0;
    bus.mem_wr_addr = 5'd4;
    bus.wb_wr_en = 1'b1; bus.wb_wr_addr = 5'd3; bus.wb_wdata = 32'h3333;
    @(negedge clk); chk("mx_stall2", bus.stall_id, 1'b1); cyc();
    bus.mem_wr_en = 1'b0; bus.mem_is_load = 1'b0;
    bus.wb_wr_addr = 5'd4; bus.wb_wdata = 32'h4444; bus.rf_rdata = {32'h0, 32'h3333};
    @(negedge clk);
    chk("mx_stall3", bus.stall_id, 1'b0);
    chk("mx_sel", bus.fwd_sel, 4'b0100);
    chk("mx_data", bus.op_data, {32'h4444, 32'h3333});
    cyc();

    // r0 never forwards.
    idle_inputs();
    bus.id_branch = 1'b1; bus.id_src_addr = '0; bus.rf_rdata = {32'hBBBB, 32'hAAAA};
    bus.ex_wr_en = 1'b1; bus.mem_wr_en = 1'b1; bus.wb_wr_en = 1'b1; bus.ex_is_load = 1'b1;
    bus.ex_alu_result = 32'h1; bus.mem_result = 32'h2; bus.wb_wdata = 32'h3;
    @(negedge clk);
    chk("r0_sel", bus.fwd_sel, 4'b0000);
    chk("r0_data", bus.op_data, {32'hBBBB, 32'hAAAA});
    chk("r0_stall", bus.stall_id, 1'b0);
    cyc();

    // EX beats MEM and WB.
    idle_inputs();
    bus.id_branch = 1'b1; bus.id_src_addr = {5'd0, 5'd9};
    bus.ex_wr_en = 1'b1; bus.ex_wr_addr = 5'd9; bus.ex_alu_result = 32'h11;
    bus.mem_wr_en = 1'b1; bus.mem_wr_addr = 5'd9; bus.mem_result = 32'h22;
    bus.wb_wr_en = 1'b1; bus.wb_wr_addr = 5'd9; bus.wb_wdata = 32'h33;
    @(negedge clk);
    chk("pri_sel", bus.fwd_sel[1:0], 2'b10);
    chk("pri_data", bus.op_data[31:0], 32'h11);
    cyc();

    // Reset asserted mid-stall drops stall_id at once.
    idle_inputs();
    bus.id_branch = 1'b1; bus.id_src_addr = {5'd0, 5'd7};
    bus.ex_wr_en = 1'b1; bus.ex_wr_addr = 5'd7; bus.ex_is_load = 1'b1;
    @(negedge clk); chk("rs_stall1", bus.stall_id, 1'b1); cyc();
    rst_n = 1'b0; bus.ex_wr_en = 1'b0; bus.ex_is_load = 1'b0;
    @(negedge clk);
    chk("rs_stall2", bus.stall_id, 1'b0);
    chk("rs_valid", bus.op_valid, 1'b0);
    cyc();
    rst_n = 1'b1;

    // Flush in the second stall cycle, counters fresh from reset.
    bus.ex_wr_en = 1'b1; bus.ex_is_load = 1'b1;
    @(negedge clk); cyc();
    bus.ex_wr_en = 1'b0; bus.ex_is_load = 1'b0; bus.flush = 1'b1;
    @(negedge clk); chk("fl_stall", bus.stall_id, 1'b0); cyc();
    bus.flush = 1'b0;
`ifdef BRANCH_FWD_PERF_CNT_EN
    exp_sc = 32'd1;
`else
    exp_sc = 32'd0;
`endif
    @(negedge clk);
    chk("fl_idle", bus.stall_id, 1'b0);
    chk("fl_cnt", bus.stall_cycles, exp_sc);
    cyc();

    // Randomized traffic with small register range to provoke matches.
    for (int i = 0; i < 1500; i++) begin
      rst_n         = ($urandom_range(0, 99) != 0);
      bus.flush     = ($urandom_range(0, 19) == 0);
      bus.id_branch = ($urandom_range(0, 4) != 0);
      for (int k = 0; k < NS; k++) begin
        bus.id_src_addr[k*AW +: AW] = AW'($urandom_range(0, 7));
        bus.rf_rdata[k*DW +: DW]    = $urandom;
      end
      bus.ex_wr_en      = ($urandom_range(0, 9) < 7);
      bus.ex_wr_addr    = AW'($urandom_range(0, 7));
      bus.ex_is_load    = ($urandom_range(0, 9) < 3);
      bus.ex_alu_result = $urandom;
      bus.mem_wr_en     = ($urandom_range(0, 9) < 7);
      bus.mem_wr_addr   = AW'($urandom_range(0, 7));
      bus.mem_is_load   = ($urandom_range(0, 9) < 3);
      bus.mem_result    = $urandom;
      bus.wb_wr_en      = ($urandom_range(0, 9) < 7);
      bus.wb_wr_addr    = AW'($urandom_range(0, 7));
      bus.wb_wdata      = $urandom;
      @(negedge clk);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/branch_operand_fwd.md
Name: branch_operand_fwd

Overview:
Parametrised operand-forwarding and hazard-stall unit for the ID-stage branch comparator of the 5-stage pipeline.
- Selects each branch source operand from the register file, EX ALU result, MEM result or WB write data.
- Owns a stall FSM that holds ID for the exact number of cycles a load-producer needs, then forwards from WB.
- Sits between the register file and the branch comparator; its stall_id output feeds the pipeline control.

Parameters:
DATA_W, 32, operand/data width
REG_AW, 5, register address width
NUM_SRC, 2, number of branch source operand channels

Ports:
clk  in  1  pipeline clock (one clock domain)
rst_n  in  1  reset, asynchronous, active-low
flush  in  1  pipeline flush; aborts any stall
id_branch  in  1  valid branch instruction in ID
id_src_addr  in  NUM_SRC*REG_AW  source register addresses, channel k at [k*REG_AW +: REG_AW]
rf_rdata  in  NUM_SRC*DATA_W  register file read data per channel
ex_wr_en  in  1  EX instruction writes a register
ex_wr_addr  in  REG_AW  EX destination register
ex_is_load  in  1  EX instruction is a load
ex_alu_result  in  DATA_W  EX ALU output
mem_wr_en  in  1  MEM instruction writes a register
mem_wr_addr  in  REG_AW  MEM destination register
mem_is_load  in  1  MEM instruction is a load
mem_result  in  DATA_W  MEM ALU result (non-load)
wb_wr_en  in  1  WB writes a register
wb_wr_addr  in  REG_AW  WB destination register
wb_wdata  in  DATA_W  WB write data
op_data  out  NUM_SRC*DATA_W  selected operands
fwd_sel  out  NUM_SRC*2  per channel: 00 RF, 10 EX, 11 MEM, 01 WB
op_valid  out  1  operands usable by the comparator this cycle
stall_id  out  1  hold PC/IF/ID, insert bubble into EX
stall_cycles  out  32  performance counter (optional feature)
fwd_events  out  32  performance counter (optional feature)

Behaviour:
- Match rule, per channel: producer stage wr_en=1 AND addr equal AND addr != 0. Register 0 is never forwarded; it always reads RF.
- Selection priority is EX > MEM > WB > RF. Every fwd_sel code is fully decoded. No latch and no hold-last-value behaviour.
- op_data is combinational from the current inputs and fwd_sel.
- Hazard requirement per channel, evaluated in IDLE with id_branch=1:
  - EX match with ex_is_load=1 -> need 2 stall cycles.
  - Else MEM match with mem_is_load=1 -> need 1.
  - Else 0.
  - The overall requirement N is the maximum over all channels.
- FSM states IDLE, STALL. 2-bit counter cnt.
- IDLE:
  - N=0 -> stall_id=0; forwarding active.
  - N>0 -> stall_id=1 that same cycle, cnt<=N-1, go STALL if N=2; else stay IDLE (one-cycle stall; re-evaluated next cycle).
- STALL:
  - stall_id=1 unconditionally.
  - Pipeline inputs are ignored for hazard purposes.
  - cnt decrements; at cnt=0 -> IDLE.
  - Next IDLE cycle re-evaluates; the load is then in WB, so select 01.
- op_valid = id_branch AND NOT stall_id AND NOT flush.
- flush=1 in any state:
  - stall_id=0 that cycle; FSM -> IDLE, cnt -> 0.
  - Flush wins over a simultaneous new hazard.
- id_branch dropping while in STALL does not shorten the stall; only flush aborts it.
- Reset (async, rst_n=0): state IDLE, cnt 0, counters 0.
  - stall_id=0 and op_valid=0 while in reset.
  - fwd_sel/op_data follow the combinational rule (RF when no matches).
  - Reset mid-stall drops stall_id immediately.

Optional Feature:
BRANCH_FWD_PERF_CNT_EN
- Defined:
  - stall_cycles increments every cycle stall_id=1.
  - fwd_events increments every cycle op_valid=1 with any fwd_sel != 00.
  - Both saturate at 32'hFFFFFFFF and clear only on reset.
- Undefined: both outputs tied to 0; no counter flops.

Test Plan:
- Channel 0: src=5, EX wr 5, ex_alu_result=0x1234, not load -> fwd_sel[1:0]=10, op_data=0x1234, stall_id=0, op_valid=1.
- src=7, EX load to r7 -> stall_id=1 for exactly 2 cycles. Third cycle, WB wr r7 with 0xDEADBEEF -> fwd_sel=01, op_data=0xDEADBEEF, op_valid=1.
- src0=3 matches MEM load r3, src1=4 matches EX load r4 -> 2-cycle stall (max of channels), then both channels resolved.
- src=0 with EX/MEM/WB all writing r0 -> fwd_sel=00, op_data=rf_rdata.
- EX and MEM both write r9 (0x11 vs 0x22) -> EX priority, op_data=0x11.
- Flush in the 2nd stall cycle -> stall_id=0 that cycle, FSM IDLE. Also rst_n low mid-stall -> stall_id=0 immediately. With BRANCH_FWD_PERF_CNT_EN, stall_cycles counts only the stalled cycles (1 for the flush case).
